// File: rtl/inst_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : inst_fetch                                                  |
// | Description : Instruction fetch stage. Issues one word-aligned memory     |
// |               request at a time, buffers returned instructions in a       |
// |               2-entry {pc, inst} FIFO and presents the FIFO head to       |
// |               decode. A redirect flushes the FIFO, restarts fetch at the  |
// |               new target and drops any response still in flight.          |
// | Revision    : 1.0  initial release                                        |
// +---------------------------------------------------------------------------+
// | Ports                                                                     |
// |   clk_i          in   1   clock, rising edge                              |
// |   rst_i          in   1   asynchronous active-high reset                  |
// |   stall_i        in   1   decode cannot accept; hold presented inst       |
// |   redirect_i     in   1   branch/jump taken; flush and restart fetch      |
// |   redirect_pc_i  in   32  new fetch target (low two bits ignored)         |
// |   imem_req_o     out  1   memory request                                  |
// |   imem_addr_o    out  32  word-aligned request address                    |
// |   imem_gnt_i     in   1   request accepted this cycle                     |
// |   imem_rvalid_i  in   1   read data valid                                 |
// |   imem_rdata_i   in   32  read instruction                                |
// |   pc_o           out  32  PC of presented instruction (0 when invalid)    |
// |   inst_o         out  32  presented instruction (NOP_INST when invalid)   |
// |   inst_valid_o   out  1   pc_o/inst_o carry a real instruction            |
// +---------------------------------------------------------------------------+
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  // S_DROP: a request is outstanding whose response must be thrown away
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] req_pc_q;

  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_inst [2];
  logic        head_q;
  logic [1:0]  count_q;

  logic        fire;
  logic        push;
  logic        pop;
  logic        tail;

  // The low two bits of the redirect target never reach the fetch PC.
  logic        unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // Request only when the FIFO still has room for the response; with a
  // single outstanding request this keeps count within 0..2.
  assign imem_req_o  = (state_q == S_REQ) && (count_q != 2'd2) && !rst_i;
  assign imem_addr_o = {pc_q[31:2], 2'b00};

  assign fire = imem_req_o && imem_gnt_i;

  // Redirect wins over push and pop: the whole FIFO is discarded anyway.
  assign push = (state_q == S_WAIT) && imem_rvalid_i && !redirect_i;
  assign pop  = inst_valid_o && !stall_i && !redirect_i;

  // A push only happens with count 0 or 1, so the tail is head + count[0].
  assign tail = head_q ^ count_q[0];

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        // A request granted alongside a redirect targets the old stream.
        if (fire) begin
          state_d = redirect_i ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = S_REQ;
        end else if (redirect_i) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid_i) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = {redirect_pc_i[31:2], 2'b00};
    end else if (fire) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // ---------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      head_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (fire) begin
        req_pc_q <= pc_q;
      end
      if (redirect_i) begin
        head_q  <= 1'b0;
        count_q <= 2'd0;
      end else begin
        if (pop) begin
          head_q <= ~head_q;
        end
        if (push && !pop) begin
          count_q <= count_q + 2'd1;
        end else if (pop && !push) begin
          count_q <= count_q - 2'd1;
        end
      end
    end
  end

  // FIFO payload needs no reset: it is only observed while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_pc[tail]   <= req_pc_q;
      fifo_inst[tail] <= imem_rdata_i;
    end
  end

  // ---------------------------------------------------------------------
  // Decode-facing outputs
  // ---------------------------------------------------------------------
  assign inst_valid_o = (count_q != 2'd0);
  assign pc_o         = inst_valid_o ? fifo_pc[head_q]   : 32'h0000_0000;
  assign inst_o       = inst_valid_o ? fifo_inst[head_q] : NOP_INST;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : tb_inst_fetch                                               |
// | Description : Self-checking bench for inst_fetch. A memory model answers  |
// |               requests with random grant/latency; a program-order model   |
// |               predicts the {pc, inst} stream decode must see; a monitor   |
// |               compares every consumed instruction against it.             |
// | Revision    : 1.0  initial release                                        |
// +---------------------------------------------------------------------------+
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  inst_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .inst_valid_o  (inst_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int total  = 0;
  int passed = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endfunction

  task automatic timeout_fail(input string what);
    total++;
    $display("FAIL timeout_%s: got no event expected event within bound at %0t", what, $time);
  endtask

  // Memory contents: a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  // Program-order reference: instructions decode must still receive.
  entry_t      exp_q[$];
  logic [31:0] model_pc = RESET_PC;

  // Stimulus knobs
  int          gnt_pct = 100, stall_pct = 0, redir_pct = 0, dly_min = 0, dly_max = 0;
  bit          hold_stall = 0;
  bit          redir_now = 0;
  bit          redir_on_rv = 0;
  bit          redir_in_wait = 0;
  logic [31:0] redir_tgt = 32'h0;

  // Memory-side state
  bit          outstanding = 0;
  bit          killed = 0;
  bit          stale = 0;
  int          dly = 0;
  logic [31:0] out_addr = 32'h0;
  bit          rv_accept = 0;

  // -------------------------------------------------------------------------
  // Stimulus + memory model + reference model (inputs change at negedge)
  // -------------------------------------------------------------------------
  initial begin : stim
    bit stale_now;
    forever begin
      @(negedge clk_i);
      rv_accept = 0;
      if (rst_i) begin
        imem_gnt_i = 0; imem_rvalid_i = 0; redirect_i = 0; stall_i = 0;
        exp_q.delete();
        model_pc = RESET_PC;
        if (outstanding) begin stale = 1; outstanding = 0; end
        continue;
      end
      stale_now     = stale;
      imem_rvalid_i = 0;
      imem_rdata_i  = $urandom;
      if (stale) begin
        // late answer to the request abandoned by reset
        imem_rvalid_i = 1; imem_rdata_i = 32'hDEAD_BEEF; stale = 0;
      end else if (outstanding) begin
        if (dly == 0) begin
          imem_rvalid_i = 1;
          imem_rdata_i  = killed ? 32'hDEAD_BEEF : mem_word(out_addr);
        end else begin
          dly--;
        end
      end

      redirect_i = 0;
      if (redir_now) begin
        redirect_i = 1; redirect_pc_i = redir_tgt; redir_now = 0;
      end else if (redir_on_rv && imem_rvalid_i && !stale_now) begin
        redirect_i = 1; redirect_pc_i = redir_tgt; redir_on_rv = 0;
      end else if (redir_in_wait && outstanding && !imem_rvalid_i) begin
        redirect_i = 1; redirect_pc_i = redir_tgt; redir_in_wait = 0;
      end else if (int'($urandom_range(99)) < redir_pct) begin
        redirect_i = 1; redirect_pc_i = $urandom;
      end
      stall_i    = hold_stall || (int'($urandom_range(99)) < stall_pct);
      imem_gnt_i = !stale_now && (int'($urandom_range(99)) < gnt_pct);

      #1;
      if (imem_req_o) check("req_while_outstanding", 32'(outstanding), 32'h0);
      if (imem_rvalid_i && outstanding) begin
        outstanding = 0;
        rv_accept   = !killed && !redirect_i;
        killed      = 0;
      end
      if (imem_req_o && imem_gnt_i) begin
        check("imem_addr", imem_addr_o, model_pc);
        outstanding = 1;
        killed      = redirect_i;
        out_addr    = imem_addr_o;
        dly         = int'($urandom_range(dly_max, dly_min));
      end else if (outstanding && redirect_i) begin
        killed = 1;
      end

      if (redirect_i) begin
        exp_q.delete();
        model_pc = {redirect_pc_i[31:2], 2'b00};
      end else if (imem_req_o && imem_gnt_i) begin
        exp_q.push_back(entry_t'({model_pc, mem_word(model_pc)}));
        model_pc = model_pc + 32'd4;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Monitor / scoreboard
  // -------------------------------------------------------------------------
  initial begin : mon
    bit          p_redirect;
    bit          p_rv;
    bit          p_hold;
    logic [31:0] p_pc;
    logic [31:0] p_inst;
    entry_t      e;
    p_redirect = 0; p_rv = 0; p_hold = 0; p_pc = 0; p_inst = 0;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_i) begin
        p_redirect = 0; p_rv = 0; p_hold = 0;
        continue;
      end
      if (p_redirect) check("valid_after_redirect", 32'(inst_valid_o), 32'h0);
      if (p_rv)       check("valid_after_rvalid", 32'(inst_valid_o), 32'h1);
      if (p_hold) begin
        check("stall_hold_valid", 32'(inst_valid_o), 32'h1);
        check("stall_hold_pc", pc_o, p_pc);
        check("stall_hold_inst", inst_o, p_inst);
      end
      if (!inst_valid_o) begin
        check("idle_pc", pc_o, 32'h0);
        check("idle_inst", inst_o, NOP_INST);
      end else if (!stall_i && !redirect_i) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL spurious_inst: got pc %h inst %h expected nothing at %0t", pc_o, inst_o, $time);
        end else begin
          e = exp_q.pop_front();
          check("consumed_pc", pc_o, e.pc);
          check("consumed_inst", inst_o, e.inst);
        end
      end
      p_redirect = redirect_i;
      p_rv       = rv_accept;
      p_hold     = inst_valid_o && stall_i && !redirect_i;
      p_pc       = pc_o;
      p_inst     = inst_o;
    end
  end

  // -------------------------------------------------------------------------
  // Directed scenarios followed by random traffic
  // -------------------------------------------------------------------------
  task automatic sync();
    @(negedge clk_i);
    #4;
  endtask

  initial begin : main
    int n;
    // reset state
    #2;
    check("rst_valid", 32'(inst_valid_o), 32'h0);
    check("rst_inst", inst_o, NOP_INST);
    check("rst_pc", pc_o, 32'h0);
    check("rst_req", 32'(imem_req_o), 32'h0);
    @(negedge clk_i);
    #3 rst_i = 0;
    #1;
    check("first_req", 32'(imem_req_o), 32'h1);
    check("first_addr", imem_addr_o, RESET_PC);

    // zero-wait streaming
    repeat (12) sync();

    // stall until the FIFO fills, starting again from 0x0
    redir_tgt = 32'h0; redir_now = 1; hold_stall = 1;
    repeat (8) sync();
    check("full_req", 32'(imem_req_o), 32'h0);
    check("full_pc", pc_o, 32'h0);
    check("full_inst", inst_o, mem_word(32'h0));
    hold_stall = 0;
    repeat (10) sync();

    // redirect while waiting; the late response must be dropped
    dly_min = 2; dly_max = 2;
    redir_tgt = 32'h0000_0100; redir_in_wait = 1;
    n = 0;
    while (redir_in_wait && n < 50) begin sync(); n++; end
    sync();
    n = 0;
    while (!imem_req_o && n < 50) begin sync(); n++; end
    if (!imem_req_o) timeout_fail("req_after_drop");
    else check("addr_after_drop", imem_addr_o, 32'h0000_0100);
    repeat (10) sync();

    // misaligned redirect target
    dly_min = 0; dly_max = 1;
    redir_tgt = 32'h0000_0103; redir_now = 1;
    n = 0;
    while (redir_now && n < 50) begin sync(); n++; end
    sync();
    n = 0;
    while (!imem_req_o && n < 50) begin sync(); n++; end
    if (!imem_req_o) timeout_fail("req_misaligned");
    else check("addr_misaligned", imem_addr_o, 32'h0000_0100);
    n = 0;
    while (!inst_valid_o && n < 50) begin sync(); n++; end
    if (!inst_valid_o) timeout_fail("valid_misaligned");
    else check("pc_misaligned", pc_o, 32'h0000_0100);
    repeat (6) sync();

    // redirect coincident with rvalid while stalled
    dly_min = 1; dly_max = 1;
    redir_tgt = 32'h0000_0200; redir_on_rv = 1; hold_stall = 1;
    n = 0;
    while (redir_on_rv && n < 50) begin sync(); n++; end
    if (redir_on_rv) timeout_fail("redir_on_rvalid");
    sync();
    check("flush_valid", 32'(inst_valid_o), 32'h0);
    check("flush_req", 32'(imem_req_o), 32'h1);
    check("flush_addr", imem_addr_o, 32'h0000_0200);
    hold_stall = 0;
    repeat (8) sync();

    // asynchronous reset in the middle of a wait
    dly_min = 3; dly_max = 3;
    n = 0;
    while (!(outstanding && dly >= 1 && !imem_req_o) && n < 50) begin sync(); n++; end
    if (!(outstanding && dly >= 1 && !imem_req_o)) timeout_fail("wait_state");
    rst_i = 1;
    #1;
    check("arst_valid", 32'(inst_valid_o), 32'h0);
    check("arst_inst", inst_o, NOP_INST);
    check("arst_pc", pc_o, 32'h0);
    check("arst_req", 32'(imem_req_o), 32'h0);
    @(negedge clk_i);
    #3 rst_i = 0;
    #1;
    check("rerun_req", 32'(imem_req_o), 32'h1);
    check("rerun_addr", imem_addr_o, RESET_PC);
    repeat (12) sync();

    // random traffic
    gnt_pct = 70; stall_pct = 30; redir_pct = 3; dly_min = 0; dly_max = 3;
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 200) begin
        redir_tgt = $urandom; redir_on_rv = 1;
      end
      sync();
    end

    // drain
    stall_pct = 0; redir_pct = 0; redir_on_rv = 0; gnt_pct = 100;
    repeat (30) sync();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
